camera_capture: RTL and testbench

Front-end capture block converting the camera's 8-bit parallel bus (VSYNC/HREF/D[7:0], two bytes per pixel, RGB565 high byte first) into the per-pixel stream consumed by `vision_process`: `frame_x_count`, `frame_y_count`, `pixel_data`, `pixel_valid`. Runs entirely in the camera pixel-clock domain. It also reports frame boundaries and whether each frame had the expected geometry.

---
 rtl/camera_capture.sv | 132 +++++++++++++
 tb/tb_camera_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture.sv
// Camera parallel-bus front end: assembles RGB565 pixels from byte pairs and
// tracks x/y position plus per-frame geometry. pixel_valid is a one-cycle strobe with no backpressure.
module camera_capture #(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240
) (
    input  logic        pixel_clock_in,
    input  logic        reset_n,
    input  logic        vsync_in,
    input  logic        href_in,
    input  logic [7:0]  data_in,
    output logic [9:0]  frame_x_count,
    output logic [8:0]  frame_y_count,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        VBLANK    = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        href_q;
    logic        phase;
    logic [7:0]  high_byte;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [9:0]  row_cnt;
    logic        err;

    logic        frame_end;
    logic        row_end;
    logic        take_byte;
    logic        in_frame;
    logic [8:0]  y_after;
    logic        err_after;
    logic        ok_now;

    always_ff @(posedge pixel_clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_SYNC: if (vsync_in)  state_nx = VBLANK;
            VBLANK:    if (!vsync_in) state_nx = ACTIVE;
            ACTIVE:    if (vsync_in)  state_nx = VBLANK;
            default:   state_nx = WAIT_SYNC;
        endcase
    end

    // A row ending on the same edge that vsync rises still counts toward the frame.
    always_comb begin
        frame_end = (state == ACTIVE) && vsync_in;
        row_end   = (state == ACTIVE) && href_q && !href_in;
        take_byte = (state == ACTIVE) && !vsync_in && href_in;
        in_frame  = (x < 10'(FRAME_WIDTH)) && (y < 9'(FRAME_HEIGHT));
        y_after   = y;
        err_after = err;
        if (row_end) begin
            if (y < 9'(FRAME_HEIGHT)) y_after = y + 9'd1;
            if ((row_cnt != 10'(FRAME_WIDTH)) || phase || (y == 9'(FRAME_HEIGHT)))
                err_after = 1'b1;
        end
        ok_now = (y_after == 9'(FRAME_HEIGHT)) && !err_after && !href_in;
    end

    always_ff @(posedge pixel_clock_in or negedge reset_n) begin
        if (!reset_n) begin
            href_q      <= 1'b0;
            phase       <= 1'b0;
            high_byte   <= 8'h00;
            x           <= 10'd0;
            y           <= 9'd0;
            row_cnt     <= 10'd0;
            err         <= 1'b0;
            pixel_data  <= 16'h0000;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= frame_end;
            frame_ok    <= frame_end && ok_now;
            href_q      <= take_byte;
            if ((state != ACTIVE) || frame_end) begin
                phase   <= 1'b0;
                x       <= 10'd0;
                y       <= 9'd0;
                row_cnt <= 10'd0;
                err     <= 1'b0;
            end else if (row_end) begin
                phase   <= 1'b0;
                x       <= 10'd0;
                y       <= y_after;
                row_cnt <= 10'd0;
                err     <= err_after;
            end else begin
                if (pixel_valid && (x < 10'(FRAME_WIDTH))) x <= x + 10'd1;
                if (take_byte) begin
                    if (!phase) begin
                        high_byte <= data_in;
                        phase     <= 1'b1;
                    end else begin
                        phase      <= 1'b0;
                        pixel_data <= {high_byte, data_in};
                        if (in_frame) pixel_valid <= 1'b1;
                        else          err         <= 1'b1;
                        // Saturate one past the width so over-long rows stay distinguishable.
                        if (row_cnt <= 10'(FRAME_WIDTH)) row_cnt <= row_cnt + 10'd1;
                    end
                end
            end
        end
    end

    assign frame_x_count = x;
    assign frame_y_count = y;
    assign state_dbg     = state;

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture at 16x12: directed frames driven byte by byte, a
// frame-level model of expected pixels/frame results, and a per-cycle compare process.
module tb_camera_capture;

    localparam int W = 16;
    localparam int H = 12;
    localparam logic [15:0] GREEN = 16'h07E0;

    logic        clk;
    logic        reset_n;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic [9:0]  frame_x_count;
    logic [8:0]  frame_y_count;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        frame_done;
    logic        frame_ok;
    logic [1:0]  state_dbg;

    camera_capture #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .pixel_clock_in(clk),
        .reset_n(reset_n),
        .vsync_in(vsync),
        .href_in(href),
        .data_in(data),
        .frame_x_count(frame_x_count),
        .frame_y_count(frame_y_count),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .frame_done(frame_done),
        .frame_ok(frame_ok),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [34:0] exp_q[$];
    logic        frame_q[$];
    int          n_checks = 0;
    int          n_errs   = 0;

    // model state
    bit armed = 0;
    bit active = 0;
    int frame_row = 0;
    bit bad = 0;

    // compare-side observations
    bit          prev_pv = 0;
    int          frame_strobes = 0;
    int          last_strobes = 0;
    logic        last_ok = 1'b0;
    int          frames_seen = 0;
    logic [9:0]  max_x = 10'd0;
    logic [15:0] r6_data = 16'h0000;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic send_row(input int nbytes, input logic [15:0] first_pix, input bit finish);
        logic [15:0] pix;
        for (int k = 0; k < nbytes; k++) begin
            pix  = (k < 2) ? first_pix : GREEN;
            href = 1'b1;
            data = (k % 2 == 0) ? pix[15:8] : pix[7:0];
            if ((k % 2 == 1) && active && (k / 2 < W) && (frame_row < H))
                exp_q.push_back({10'(k / 2), 9'(frame_row), pix});
            cyc();
        end
        if (finish) begin
            href = 1'b0;
            data = 8'h00;
            if (nbytes != 2 * W) bad = 1'b1;
            frame_row++;
            repeat (4) cyc();
        end
    endtask

    task automatic run_rows(input int nrows, input int long_row, input int odd_row);
        int          nb;
        logic [15:0] fp;
        for (int r = 0; r < nrows; r++) begin
            nb = (r == long_row) ? 36 : (r == odd_row) ? 33 : 32;
            fp = (odd_row >= 0 && r == odd_row + 1) ? 16'hF800 : GREEN;
            send_row(nb, fp, 1'b1);
        end
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        if (active) frame_q.push_back((frame_row == H) && !bad);
        active = 1'b0;
        armed  = 1'b1;
        cyc();
        href = 1'b0;
        cyc();
        cyc();
        vsync     = 1'b0;
        active    = armed;
        frame_row = 0;
        bad       = 1'b0;
        repeat (3) cyc();
    endtask

    // compare process
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_pv       = 0;
            frame_strobes = 0;
        end else begin
            if (pixel_valid) begin
                chk("pv_not_back_to_back", 64'(prev_pv), 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_strobe: got x=%0d y=%0d data=%0h, expected no strobe",
                             frame_x_count, frame_y_count, pixel_data);
                end else begin
                    chk("pixel_xyd", {frame_x_count, frame_y_count, pixel_data}, exp_q.pop_front());
                end
                frame_strobes++;
                if (frame_x_count > max_x) max_x = frame_x_count;
                if (frame_x_count == 10'd0 && frame_y_count == 9'd6) r6_data = pixel_data;
            end
            if (frame_done) begin
                if (frame_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_frame_done: got frame_done=1, expected 0");
                end else begin
                    chk("frame_ok", 64'(frame_ok), 64'(frame_q.pop_front()));
                end
                last_strobes  = frame_strobes;
                last_ok       = frame_ok;
                frame_strobes = 0;
                frames_seen++;
            end else begin
                chk("frame_ok_unqualified", 64'(frame_ok), 64'd0);
            end
            prev_pv = pixel_valid;
        end
    end

    // main sequence
    initial begin
        reset_n = 1'b0;
        vsync   = 1'b0;
        href    = 1'b0;
        data    = 8'h00;
        repeat (3) cyc();
        chk("reset_outputs",
            {frame_x_count, frame_y_count, pixel_data, pixel_valid, frame_done, frame_ok}, 64'd0);
        reset_n = 1'b1;
        cyc();

        // bytes before the first vsync are ignored
        run_rows(2, -1, -1);
        chk("no_strobes_before_vsync", 64'(frame_strobes), 64'd0);

        vsync_pulse();
        run_rows(12, -1, -1);
        vsync_pulse();
        chk("f_green_strobes", 64'(last_strobes), 64'd192);
        chk("f_green_ok", 64'(last_ok), 64'd1);

        run_rows(12, 3, -1);
        vsync_pulse();
        chk("f_long_strobes", 64'(last_strobes), 64'd192);
        chk("f_long_ok", 64'(last_ok), 64'd0);

        run_rows(12, -1, 5);
        vsync_pulse();
        chk("f_odd_strobes", 64'(last_strobes), 64'd192);
        chk("f_odd_ok", 64'(last_ok), 64'd0);
        chk("f_odd_row6_first_pixel", 64'(r6_data), 64'h F800);

        run_rows(13, -1, -1);
        vsync_pulse();
        chk("f_13rows_strobes", 64'(last_strobes), 64'd192);
        chk("f_13rows_ok", 64'(last_ok), 64'd0);

        run_rows(11, -1, -1);
        vsync_pulse();
        chk("f_11rows_strobes", 64'(last_strobes), 64'd176);
        chk("f_11rows_ok", 64'(last_ok), 64'd0);

        // vsync rises with href still high, two pixels into row 2
        run_rows(2, -1, -1);
        send_row(5, GREEN, 1'b0);
        vsync_pulse();
        chk("f_abort_strobes", 64'(last_strobes), 64'd34);
        chk("f_abort_ok", 64'(last_ok), 64'd0);

        // frame with no rows at all
        vsync_pulse();
        chk("f_empty_strobes", 64'(last_strobes), 64'd0);
        chk("f_empty_ok", 64'(last_ok), 64'd0);

        // reset pulse in the middle of row 7, with a strobe pending
        run_rows(7, -1, -1);
        send_row(10, GREEN, 1'b0);
        reset_n = 1'b0;
        exp_q.delete();
        armed     = 0;
        active    = 0;
        frame_row = 0;
        bad       = 1'b0;
        #1;
        chk("midrow_reset_outputs",
            {frame_x_count, frame_y_count, pixel_data, pixel_valid, frame_done, frame_ok}, 64'd0);
        cyc();
        reset_n = 1'b1;
        send_row(22, GREEN, 1'b1);
        run_rows(2, -1, -1);
        chk("no_strobes_after_reset", 64'(frame_strobes), 64'd0);
        vsync_pulse();
        run_rows(12, -1, -1);
        vsync_pulse();
        chk("f_after_reset_strobes", 64'(last_strobes), 64'd192);
        chk("f_after_reset_ok", 64'(last_ok), 64'd1);

        repeat (4) cyc();
        chk("frames_seen", 64'(frames_seen), 64'd8);
        chk("pixels_outstanding", 64'(exp_q.size()), 64'd0);
        chk("frames_outstanding", 64'(frame_q.size()), 64'd0);
        chk("max_x_le_15", 64'(max_x <= 10'd15), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
